// File: rtl/instr_fetch.sv
// instr_fetch: multi-cycle fetch stage owning the PC, holding each instruction for EXEC_CYCLES clocks
module instr_fetch #(
   parameter logic [31:0] RESET_PC    = 32'h00000000,
   parameter int          EXEC_CYCLES = 5,
   parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCSel,
   input  logic [31:0] alu_result,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [3:0]  phase,
   output logic        trap
);
   typedef enum logic [1:0] {REQ, WAIT, EXEC, HALT} state_t;
   localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);
   state_t      state, state_n;
   logic [31:0] pc_n, instr_n;
   logic [3:0]  phase_n;
   logic        req_n, valid_n, trap_n;
   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;
   always_comb begin
      state_n = state;
      pc_n    = pc;
      instr_n = instr;
      valid_n = instr_valid;
      phase_n = phase;
      trap_n  = trap;
      req_n   = 1'b0;
      unique case (state)
         // after reset imem_req is low, so REQ spends one cycle raising it
         REQ: begin
            state_n = imem_req ? WAIT : REQ;
            req_n   = !imem_req;
         end
         WAIT: if (imem_valid) begin
            instr_n = imem_rdata;
            valid_n = 1'b1;
            phase_n = 4'd0;
            state_n = EXEC;
         end
         EXEC: if (phase == LAST) begin
            phase_n = 4'd0;
            valid_n = 1'b0;
            instr_n = NOP_INSTR;
            if (PCSel && alu_result[1:0] != 2'b00) begin
               trap_n  = 1'b1;
               state_n = HALT;
            end else begin
               pc_n    = PCSel ? alu_result : pc_plus4;
               req_n   = 1'b1;
               state_n = REQ;
            end
         end else
            phase_n = phase + 4'd1;
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= REQ;
         pc          <= RESET_PC;
         instr       <= NOP_INSTR;
         instr_valid <= 1'b0;
         phase       <= 4'd0;
         trap        <= 1'b0;
         imem_req    <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         instr       <= instr_n;
         instr_valid <= valid_n;
         phase       <= phase_n;
         trap        <= trap_n;
         imem_req    <= req_n;
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized bench for instr_fetch against a per-instruction PC/memory model
module tb_instr_fetch;
   localparam int          E   = 5;
   localparam logic [31:0] RPC = 32'h00000000;
   localparam logic [31:0] NOP = 32'h00000013;
   logic        clk = 1'b0, rst = 1'b1, PCSel = 1'b0, imem_valid = 1'b0;
   logic [31:0] alu_result = '0, imem_rdata = '0;
   logic        imem_req, instr_valid, trap;
   logic [31:0] imem_addr, instr, pc, pc_plus4;
   logic [3:0]  phase;
   int          tests = 0, fails = 0;
   logic [31:0] exp_pc;
   bit          halted;
   instr_fetch #(.RESET_PC(RPC), .EXEC_CYCLES(E), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .PCSel(PCSel), .alu_result(alu_result),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid), .imem_req(imem_req),
      .imem_addr(imem_addr), .instr(instr), .instr_valid(instr_valid), .pc(pc),
      .pc_plus4(pc_plus4), .phase(phase), .trap(trap)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running required done");
      $fatal(1, "watchdog");
   end
   // memory contents: address 0 holds addi x1,x0,5
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h00500093;
   endfunction
   task automatic tick;
      @(negedge clk);
   endtask
   task automatic do_reset;
      rst = 1'b1; PCSel = 1'b0; imem_valid = 1'b0;
      tick;
      rst = 1'b0; exp_pc = RPC; halted = 0;
   endtask
   // one full instruction: request, lat wait cycles, EXEC, then exit checks
   task automatic run_instr(input int lat, input bit sel, input logic [31:0] tgt,
                            input bit early, input int rst_phase);
      int n;
      logic [31:0] d;
      n = 0;
      while (imem_req !== 1'b1 && n < 20) begin tick; n++; end
      tests++;
      if (imem_req !== 1'b1) begin
         fails++; $display("FAIL req_timeout: imem_req got %b required 1", imem_req); return;
      end
      tests++;
      if (imem_addr !== exp_pc) begin
         fails++; $display("FAIL req_addr: got %h required %h", imem_addr, exp_pc);
      end
      d = mem_word(imem_addr);
      tick;
      for (int i = 0; i <= lat; i++) begin
         tests++;
         if ({imem_req, instr_valid, instr} !== {1'b0, 1'b0, NOP}) begin
            fails++; $display("FAIL wait_out: got req=%b v=%b i=%h required 0 0 %h", imem_req, instr_valid, instr, NOP);
         end
         if (i < lat) tick;
      end
      imem_valid = 1'b1; imem_rdata = d;
      tick;
      imem_valid = 1'b0;
      for (int p = 0; p < E; p++) begin
         tests++;
         if ({instr, instr_valid, phase, pc, pc_plus4, trap, imem_req} !==
             {mem_word(exp_pc), 1'b1, 4'(p), exp_pc, exp_pc + 32'd4, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL exec_p%0d: got i=%h v=%b ph=%0d pc=%h p4=%h t=%b r=%b required i=%h v=1 ph=%0d pc=%h p4=%h t=0 r=0",
                     p, instr, instr_valid, phase, pc, pc_plus4, trap, imem_req, mem_word(exp_pc), p, exp_pc, exp_pc + 32'd4);
         end
         if (p == rst_phase) begin
            rst = 1'b1; imem_valid = 1'b1; imem_rdata = $urandom;
            tick;
            rst = 1'b0;
            tests++;
            if ({instr, instr_valid, phase, pc, trap, imem_req} !== {NOP, 1'b0, 4'd0, RPC, 1'b0, 1'b0}) begin
               fails++; $display("FAIL mid_reset: got i=%h v=%b ph=%0d pc=%h t=%b r=%b required %h 0 0 %h 0 0",
                                 instr, instr_valid, phase, pc, trap, imem_req, NOP, RPC);
            end
            tick;
            imem_valid = 1'b0; exp_pc = RPC;
            return;
         end
         if (p == E - 1) begin PCSel = sel; alu_result = tgt; end
         else if (early && p == 2) begin PCSel = 1'b1; alu_result = 32'h100; end
         else begin PCSel = 1'($urandom); alu_result = $urandom; end
         imem_valid = 1'($urandom); imem_rdata = $urandom;
         tick;
      end
      imem_valid = 1'b0; PCSel = 1'b0;
      if (sel && tgt[1:0] != 2'b00) begin
         halted = 1;
         for (int i = 0; i < 4; i++) begin
            tests++;
            if ({trap, imem_req, instr_valid, instr, pc} !== {1'b1, 1'b0, 1'b0, NOP, exp_pc}) begin
               fails++; $display("FAIL halt: got t=%b r=%b v=%b i=%h pc=%h required 1 0 0 %h %h",
                                 trap, imem_req, instr_valid, instr, pc, NOP, exp_pc);
            end
            imem_valid = 1'($urandom);
            tick;
         end
         imem_valid = 1'b0;
      end else begin
         exp_pc = sel ? tgt : exp_pc + 32'd4;
         tests++;
         if ({imem_req, imem_addr, phase, instr_valid, instr, trap} !== {1'b1, exp_pc, 4'd0, 1'b0, NOP, 1'b0}) begin
            fails++; $display("FAIL exit: got r=%b a=%h ph=%0d v=%b i=%h t=%b required 1 %h 0 0 %h 0",
                              imem_req, imem_addr, phase, instr_valid, instr, trap, exp_pc, NOP);
         end
      end
   endtask
   task automatic test_reset;
      do_reset;
      tests++;
      if ({imem_req, instr_valid, instr, pc, pc_plus4, imem_addr, phase, trap} !==
          {1'b0, 1'b0, NOP, RPC, RPC + 32'd4, RPC, 4'd0, 1'b0}) begin
         fails++; $display("FAIL reset: got r=%b v=%b i=%h pc=%h ph=%0d t=%b required 0 0 %h %h 0 0",
                           imem_req, instr_valid, instr, pc, phase, trap, NOP, RPC);
      end
   endtask
   task automatic test_zero_wait;
      do_reset;
      run_instr(0, 0, 0, 0, -1);
      run_instr(0, 0, 0, 0, -1);
   endtask
   task automatic test_mem_delay;
      run_instr(3, 0, 0, 0, -1);
   endtask
   task automatic test_branch;
      run_instr(0, 1, 32'h40, 0, -1);
      run_instr(1, 0, 0, 0, -1);
   endtask
   task automatic test_early_pcsel;
      run_instr(0, 0, 0, 1, -1);
      run_instr(0, 0, 0, 0, -1);
   endtask
   task automatic test_wrap;
      run_instr(0, 1, 32'hFFFFFFFC, 0, -1);
      run_instr(0, 0, 0, 0, -1);
      run_instr(0, 0, 0, 0, -1);
   endtask
   task automatic test_trap;
      run_instr(0, 1, 32'h42, 0, -1);
      do_reset;
      tests++;
      if (trap !== 1'b0) begin fails++; $display("FAIL trap_clear: got %b required 0", trap); end
      run_instr(0, 0, 0, 0, -1);
   endtask
   task automatic test_reset_mid_exec;
      run_instr(0, 0, 0, 0, 2);
      run_instr(2, 0, 0, 0, -1);
   endtask
   task automatic test_random;
      logic [31:0] t;
      for (int k = 0; k < 40; k++) begin
         t = $urandom;
         if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
         run_instr(int'($urandom_range(0, 3)), 1'($urandom), t, 0, -1);
         if (halted) do_reset;
      end
   endtask
   initial begin
      test_reset;
      test_zero_wait;
      test_mem_delay;
      test_branch;
      test_early_pcsel;
      test_wrap;
      test_trap;
      test_reset_mid_exec;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Multi-cycle instruction fetch stage, directly upstream of the control unit.
- Owns the PC and requests instructions from instruction memory over a req/valid handshake.
- Presents one instruction to the control unit, stable for EXEC_CYCLES clocks.
- Chooses the next PC on the last execute phase: PC+4, or the branch/jump target when the control unit asserts PCSel.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- EXEC_CYCLES, 5, clocks each instruction is held for decode/execute/writeback (legal range 2..15).
- NOP_INSTR, 32'h00000013, instruction driven when no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- PCSel  in  1  from control unit; 1 = take the target on alu_result.
- alu_result  in  32  branch/jump target from the ALU.
- imem_rdata  in  32  instruction memory read data.
- imem_valid  in  1  imem_rdata valid this cycle.
- imem_req  out  1  fetch request, single-cycle pulse.
- imem_addr  out  32  fetch address (= pc).
- instr  out  32  instruction to control unit / immediate generator.
- instr_valid  out  1  instr holds a fetched instruction.
- pc  out  32  address of the current instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- phase  out  4  execute phase 0..EXEC_CYCLES-1; 0 outside EXEC.
- trap  out  1  sticky misaligned-target flag.

Behaviour:
- Reset (rst=1 at a posedge, from any state, including mid-fetch or mid-EXEC):
  - state=REQ, pc=RESET_PC, phase=0, trap=0, imem_req=0, instr=NOP_INSTR, instr_valid=0.
  - A late imem_valid arriving after reset is ignored unless the state is WAIT.
- States: REQ, WAIT, EXEC, HALT.
- REQ:
  - Drive imem_req=1 for exactly one cycle, with imem_addr=pc.
  - Next state is WAIT.
- WAIT:
  - imem_req=0; instr=NOP_INSTR; instr_valid=0.
  - On imem_valid=1: latch imem_rdata into instr, set instr_valid=1, phase=0, go to EXEC.
  - Minimum request-to-EXEC latency is 2 clocks (data valid the cycle after the request).
  - No timeout: WAIT holds indefinitely.
- EXEC:
  - instr, pc and pc_plus4 are held constant for the whole state.
  - phase increments by 1 each clock.
  - At phase==EXEC_CYCLES-1, sample PCSel and alu_result:
    - PCSel=0: next pc = pc_plus4. At pc=32'hFFFFFFFC this wraps to 0; no flag.
    - PCSel=1 and alu_result[1:0]==0: next pc = alu_result.
    - PCSel=1 and alu_result[1:0]!=0: trap=1, pc unchanged, go to HALT.
  - Normal exit: phase returns to 0, instr_valid=0, instr=NOP_INSTR, go to REQ.
  - PCSel is ignored on every other phase.
- HALT:
  - instr=NOP_INSTR, instr_valid=0, imem_req=0.
  - Only rst leaves HALT.
  - trap stays 1 until reset.
- imem_valid outside WAIT is ignored.
- Total cycles per instruction = EXEC_CYCLES + 2 with zero-wait memory.
- All outputs are registered except pc_plus4 and imem_addr (combinational from pc).

Test Plan:
- Reset then zero-wait memory returning 32'h00500093:
  - imem_req pulses at addr 0.
  - instr=32'h00500093 for 5 clocks with phase 0..4.
  - Next request at addr 4, exactly 7 clocks after the first.
- Memory with 3-cycle delay:
  - instr stays NOP_INSTR and instr_valid=0 throughout WAIT.
  - Single imem_req pulse; EXEC starts the cycle after imem_valid.
- PCSel=1 with alu_result=32'h00000040 at phase 4:
  - Next imem_addr=32'h40.
- PCSel=1 at phase 2, then 0 at phase 4:
  - Next imem_addr=pc+4 (early PCSel ignored).
- RESET_PC=32'hFFFFFFFC, PCSel=0:
  - Second fetch is at addr 0; trap=0.
- PCSel=1 with alu_result=32'h00000042:
  - trap=1, state HALT, no further imem_req.
  - rst clears trap and the next fetch is at RESET_PC.
- Assert rst during phase 2 of EXEC:
  - Next cycle instr=NOP_INSTR, pc=RESET_PC, phase=0.
  - A fresh request follows.
